// File: rtl/poker_pkg.sv
// Shared card/hand types, category encoding and the combinational five-card evaluator
// used by the showdown scheduler.
package poker_pkg;

  localparam int CARD_W     = 6;
  localparam int HAND_CARDS = 5;
  localparam int HAND_W     = CARD_W * HAND_CARDS;

  localparam logic [3:0] RANK_ACE  = 4'he;
  localparam logic [3:0] RANK_TEN  = 4'ha;
  localparam logic [3:0] RANK_TWO  = 4'h2;
  localparam logic [3:0] RANK_FIVE = 4'h5;

  typedef struct packed {
    logic [1:0] suit;
    logic [3:0] rank;
  } card_t;

  typedef card_t [HAND_CARDS-1:0] hand_t;

  typedef enum logic [3:0] {
    CAT_HIGH = 4'd0, CAT_PAIR = 4'd1, CAT_TWO_PAIR = 4'd2, CAT_TRIPS = 4'd3,
    CAT_STRAIGHT = 4'd4, CAT_FLUSH = 4'd5, CAT_FULL = 4'd6, CAT_QUADS = 4'd7,
    CAT_STR_FLUSH = 4'd8, CAT_ROYAL = 4'd9
  } category_e;

  typedef enum logic [2:0] {IDLE, ARB, SORT, EVAL, RESULT, DONE} state_e;

  typedef struct packed {
    logic royal;
    logic straight_flush;
    logic quads;
    logic full_house;
    logic flush;
    logic straight;
    logic trips;
    logic two_pair;
    logic pair;
  } eval_flags_t;

  // Expects a hand already sorted ascending by rank; every flag is raw, overlaps resolve later.
  function automatic eval_flags_t evaluate_hand(input hand_t h);
    eval_flags_t f;
    logic [3:0]  r0, r1, r2, r3, r4;
    logic        run, wheel;
    r0 = h[0].rank; r1 = h[1].rank; r2 = h[2].rank; r3 = h[3].rank; r4 = h[4].rank;
    run   = (r1 == r0 + 4'd1) && (r2 == r1 + 4'd1) && (r3 == r2 + 4'd1) && (r4 == r3 + 4'd1);
    wheel = (r0 == RANK_TWO) && (r1 == 4'd3) && (r2 == 4'd4) && (r3 == RANK_FIVE) && (r4 == RANK_ACE);
    f.flush          = (h[0].suit == h[1].suit) && (h[1].suit == h[2].suit) &&
                       (h[2].suit == h[3].suit) && (h[3].suit == h[4].suit);
    f.straight       = run || wheel;
    f.straight_flush = f.straight && f.flush;
    f.royal          = f.straight_flush && (r0 == RANK_TEN) && (r4 == RANK_ACE);
    f.quads          = (r0 == r3) || (r1 == r4);
    f.full_house     = ((r0 == r2) && (r3 == r4)) || ((r0 == r1) && (r2 == r4));
    f.trips          = (r0 == r2) || (r1 == r3) || (r2 == r4);
    f.two_pair       = ((r0 == r1) && (r2 == r3)) || ((r0 == r1) && (r3 == r4)) ||
                       ((r1 == r2) && (r3 == r4));
    f.pair           = (r0 == r1) || (r1 == r2) || (r2 == r3) || (r3 == r4);
    return f;
  endfunction

  function automatic category_e encode_category(input eval_flags_t f);
    if (f.royal)               return CAT_ROYAL;
    else if (f.straight_flush) return CAT_STR_FLUSH;
    else if (f.quads)          return CAT_QUADS;
    else if (f.full_house)     return CAT_FULL;
    else if (f.flush)          return CAT_FLUSH;
    else if (f.straight)       return CAT_STRAIGHT;
    else if (f.trips)          return CAT_TRIPS;
    else if (f.two_pair)       return CAT_TWO_PAIR;
    else if (f.pair)           return CAT_PAIR;
    else                       return CAT_HIGH;
  endfunction

endpackage

// File: rtl/card_sorter.sv
// Registered odd-even transposition sorter: ascending by rank, stable, one pass per clock.
// done is high in the cycle whose closing edge completes the final pass.
module card_sorter
  import poker_pkg::*;
#(
  parameter int SORT_CYCLES = 5
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  hand_t hand_in,
  output hand_t hand_out,
  output logic  done
);

  hand_t      cards;
  hand_t      pass_result;
  logic [3:0] pass_cnt;
  logic       running;

  assign done     = running && (pass_cnt == 4'(SORT_CYCLES - 1));
  assign hand_out = cards;

  always_ff @(posedge clk) begin
    if (rst) begin
      running  <= 1'b0;
      pass_cnt <= '0;
    end else if (load) begin
      running  <= 1'b1;
      pass_cnt <= '0;
    end else if (running) begin
      pass_cnt <= pass_cnt + 4'd1;
      if (done) running <= 1'b0;
    end
  end

  // NOTE: pure datapath registers carry no reset; their contents are only consumed after a load.
  always_ff @(posedge clk) begin
    if (load)         cards <= hand_in;
    else if (running) cards <= pass_result;
  end

  // Even passes compare (0,1),(2,3); odd passes compare (1,2),(3,4). Strict > keeps ties stable.
  always_comb begin
    pass_result = cards;
    for (int i = 0; i < HAND_CARDS - 1; i++) begin
      if ((i % 2) == int'(pass_cnt[0]) && cards[i].rank > cards[i+1].rank) begin
        pass_result[i]   = cards[i+1];
        pass_result[i+1] = cards[i];
      end
    end
  end

endmodule

// File: rtl/hand_eval_scheduler.sv
// Showdown round sequencer: round-robin grant, sort, shared evaluation and running best hand.
// One hand is in flight at a time; each served hand takes eight cycles from grant to next grant.
module hand_eval_scheduler
  import poker_pkg::*;
#(
  parameter int N_PLAYERS   = 4,
  parameter int SORT_CYCLES = 5,
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        round_start,
  input  logic [N_PLAYERS-1:0]        player_mask,
  input  logic [N_PLAYERS-1:0]        hand_valid,
  input  logic [N_PLAYERS*HAND_W-1:0] hand_data,
  output logic [N_PLAYERS-1:0]        hand_ack,
  output logic                        res_valid,
  output logic [PW-1:0]               res_player,
  output logic [3:0]                  res_category,
  output logic                        round_done,
  output logic [PW-1:0]               winner,
  output logic [3:0]                  winner_category,
  output logic                        busy
);

  state_e                 state, next_state;
  logic [N_PLAYERS-1:0]   mask_q, served, eligible, pending, hand_ack_q;
  logic [PW-1:0]          ptr, grant_idx, idx, cur_player, best_player, win_player;
  logic                   grant_any, sorter_done, best_valid, new_best;
  hand_t                  granted_hand, sorted_hand;
  eval_flags_t            flags_q;
  logic [19:0]            ranks_q, best_ranks;
  category_e              res_cat, best_cat;
  logic [3:0]             win_cat;

  assign eligible     = hand_valid & mask_q & ~served;
  assign pending      = mask_q & ~served;
  assign granted_hand = hand_data[int'(grant_idx)*HAND_W +: HAND_W];
  assign res_cat      = encode_category(flags_q);
  assign new_best     = !best_valid || (res_cat > best_cat) ||
                        ((res_cat == best_cat) && (ranks_q > best_ranks));

  // Round-robin pick: first eligible requester at or after ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      idx = PW'((int'(ptr) + i) % N_PLAYERS);
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_idx = idx;
      end
    end
  end

  card_sorter #(.SORT_CYCLES(SORT_CYCLES)) u_sorter (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ARB && grant_any),
    .hand_in  (granted_hand),
    .hand_out (sorted_hand),
    .done     (sorter_done)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (round_start) next_state = (player_mask == '0) ? DONE : ARB;
      ARB:     if (grant_any) next_state = SORT;
               else if (pending == '0) next_state = DONE;
      SORT:    if (sorter_done) next_state = EVAL;
      EVAL:    next_state = RESULT;
      RESULT:  next_state = ARB;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      mask_q      <= '0;
      served      <= '0;
      hand_ack_q  <= '0;
      cur_player  <= '0;
      flags_q     <= '0;
      ranks_q     <= '0;
      best_valid  <= 1'b0;
      best_cat    <= CAT_HIGH;
      best_ranks  <= '0;
      best_player <= '0;
      win_player  <= '0;
      win_cat     <= '0;
    end else begin
      state      <= next_state;
      hand_ack_q <= '0;
      if (state == IDLE && round_start) begin
        mask_q      <= player_mask;
        served      <= '0;
        best_valid  <= 1'b0;
        best_cat    <= CAT_HIGH;
        best_ranks  <= '0;
        best_player <= '0;
        win_player  <= '0;
        win_cat     <= '0;
      end
      if (state == ARB && grant_any) begin
        cur_player <= grant_idx;
        hand_ack_q <= {{(N_PLAYERS-1){1'b0}}, 1'b1} << grant_idx;
        ptr        <= (grant_idx == PW'(N_PLAYERS - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == ARB && next_state == DONE) begin
        win_player <= best_player;
        win_cat    <= best_cat;
      end
      if (state == EVAL) begin
        flags_q <= evaluate_hand(sorted_hand);
        ranks_q <= {sorted_hand[4].rank, sorted_hand[3].rank, sorted_hand[2].rank,
                    sorted_hand[1].rank, sorted_hand[0].rank};
      end
      if (state == RESULT) begin
        served[cur_player] <= 1'b1;
        if (new_best) begin
          best_valid  <= 1'b1;
          best_cat    <= res_cat;
          best_ranks  <= ranks_q;
          best_player <= cur_player;
        end
      end
    end
  end

  assign hand_ack        = hand_ack_q;
  assign res_valid       = (state == RESULT);
  assign res_player      = cur_player;
  assign res_category    = res_cat;
  assign round_done      = (state == DONE);
  assign winner          = win_player;
  assign winner_category = win_cat;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_hand_eval_scheduler.sv
// Directed bench for hand_eval_scheduler: expected results are queued as hands are offered
// and compared when res_valid fires; round timing is checked from logged ack/result cycles.
module tb_hand_eval_scheduler;

  localparam int N  = 4;
  localparam int PW = 2;
  localparam int S = 0, H = 1, D = 2, C = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            round_start = 1'b0;
  logic [N-1:0]    player_mask = '0;
  logic [N-1:0]    hand_valid = '0;
  logic [N*30-1:0] hand_data = '0;
  logic [N-1:0]    hand_ack;
  logic            res_valid;
  logic [PW-1:0]   res_player;
  logic [3:0]      res_category;
  logic            round_done;
  logic [PW-1:0]   winner;
  logic [3:0]      winner_category;
  logic            busy;

  typedef struct {int player; int cat;} exp_t;
  exp_t         exp_q[$];
  exp_t         exp_head;
  int           ack_cyc[$];
  logic [N-1:0] ack_vec[$];
  int           res_cyc[$];
  int           cyc = 0;
  int           done_cnt = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  int           done_before;

  hand_eval_scheduler #(.N_PLAYERS(N), .SORT_CYCLES(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .round_start     (round_start),
    .player_mask     (player_mask),
    .hand_valid      (hand_valid),
    .hand_data       (hand_data),
    .hand_ack        (hand_ack),
    .res_valid       (res_valid),
    .res_player      (res_player),
    .res_category    (res_category),
    .round_done      (round_done),
    .winner          (winner),
    .winner_category (winner_category),
    .busy            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (hand_ack != '0) begin
      ack_cyc.push_back(cyc);
      ack_vec.push_back(hand_ack);
    end
    if (res_valid) begin
      res_cyc.push_back(cyc);
      if (exp_q.size() == 0) check("res_unexpected", {31'b0, res_valid}, 32'd0);
      else begin
        exp_head = exp_q.pop_front();
        check("res_player", {30'b0, res_player}, exp_head.player);
        check("res_category", {28'b0, res_category}, exp_head.cat);
      end
    end
    if (round_done) done_cnt++;
  end

  function automatic logic [5:0] cd(input int rank, input int suit);
    return {suit[1:0], rank[3:0]};
  endfunction

  function automatic logic [29:0] mk(input logic [5:0] c0, c1, c2, c3, c4);
    return {c4, c3, c2, c1, c0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    ack_cyc.delete();
    ack_vec.delete();
    res_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic set_hand(input int p, input logic [29:0] h);
    hand_data[p*30 +: 30] = h;
  endtask

  task automatic start_round(input logic [N-1:0] mask);
    player_mask = mask;
    round_start = 1'b1;
    step();
    round_start = 1'b0;
  endtask

  task automatic wait_done(input int exp_winner, input int exp_cat);
    for (int i = 0; i < 400 && !round_done; i++) step();
    check("round_done", {31'b0, round_done}, 32'd1);
    check("busy_at_done", {31'b0, busy}, 32'd1);
    check("winner", {30'b0, winner}, exp_winner);
    check("winner_category", {28'b0, winner_category}, exp_cat);
    step();
    check("busy_after_done", {31'b0, busy}, 32'd0);
    check("round_done_pulse", {31'b0, round_done}, 32'd0);
    check("scoreboard_empty", exp_q.size(), 32'd0);
  endtask

  // Players granted in order 0..n-1: one-hot acks 8 cycles apart, result 6 cycles after ack.
  task automatic check_acks(input int n);
    check("ack_count", ack_cyc.size(), n);
    check("res_count", res_cyc.size(), n);
    for (int i = 0; i < n && i < ack_cyc.size() && i < res_cyc.size(); i++) begin
      check($sformatf("ack_onehot_%0d", i), {28'b0, ack_vec[i]}, 32'd1 << i);
      check($sformatf("ack_to_res_%0d", i), res_cyc[i] - ack_cyc[i], 32'd6);
      if (i > 0) check($sformatf("ack_spacing_%0d", i), ack_cyc[i] - ack_cyc[i-1], 32'd8);
    end
  endtask

  initial begin
    do_reset();
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_res_valid", {31'b0, res_valid}, 32'd0);
    check("reset_round_done", {31'b0, round_done}, 32'd0);
    check("reset_hand_ack", {28'b0, hand_ack}, 32'd0);
    check("reset_winner", {30'b0, winner}, 32'd0);
    check("reset_winner_cat", {28'b0, winner_category}, 32'd0);

    // 1: pair vs quads
    set_hand(0, mk(cd(3, S), cd(3, H), cd(7, D), cd(9, C), cd(12, S)));
    set_hand(1, mk(cd(5, S), cd(5, H), cd(5, D), cd(5, C), cd(8, S)));
    hand_valid = 4'b0011;
    exp_q.push_back('{0, 1});
    exp_q.push_back('{1, 7});
    start_round(4'b0011);
    wait_done(1, 7);
    check_acks(2);

    // 2: same pair hand offered in descending order
    clear_logs();
    set_hand(0, mk(cd(12, S), cd(9, C), cd(7, D), cd(3, H), cd(3, S)));
    hand_valid = 4'b0001;
    exp_q.push_back('{0, 1});
    start_round(4'b0001);
    wait_done(0, 1);

    // 3: four players valid from the start: flush, straight, royal, wheel straight-flush
    do_reset();
    set_hand(0, mk(cd(2, H), cd(5, H), cd(9, H), cd(11, H), cd(13, H)));
    set_hand(1, mk(cd(6, S), cd(7, H), cd(8, D), cd(9, C), cd(10, S)));
    set_hand(2, mk(cd(10, D), cd(11, D), cd(12, D), cd(13, D), cd(14, D)));
    set_hand(3, mk(cd(14, C), cd(2, C), cd(3, C), cd(4, C), cd(5, C)));
    hand_valid = 4'b1111;
    exp_q.push_back('{0, 5});
    exp_q.push_back('{1, 4});
    exp_q.push_back('{2, 9});
    exp_q.push_back('{3, 8});
    start_round(4'b1111);
    wait_done(2, 9);
    check_acks(4);

    // 4: all high card; P1 and P2 tie exactly, first evaluated keeps the lead
    do_reset();
    set_hand(0, mk(cd(2, S), cd(3, H), cd(5, D), cd(7, C), cd(8, S)));
    set_hand(1, mk(cd(2, S), cd(4, H), cd(6, D), cd(9, C), cd(13, S)));
    set_hand(2, mk(cd(13, H), cd(9, D), cd(6, C), cd(4, S), cd(2, H)));
    set_hand(3, mk(cd(2, C), cd(3, D), cd(4, S), cd(5, H), cd(9, C)));
    hand_valid = 4'b1111;
    for (int p = 0; p < 4; p++) exp_q.push_back('{p, 0});
    start_round(4'b1111);
    wait_done(1, 0);

    // 5: reset three cycles after the first grant abandons the round
    do_reset();
    done_before = done_cnt;
    set_hand(0, mk(cd(3, S), cd(3, H), cd(7, D), cd(9, C), cd(12, S)));
    set_hand(1, mk(cd(5, S), cd(5, H), cd(5, D), cd(5, C), cd(8, S)));
    hand_valid = 4'b0011;
    start_round(4'b0011);
    for (int i = 0; i < 20 && hand_ack == '0; i++) step();
    check("rst_test_first_ack", {28'b0, hand_ack}, 32'd1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy_low", {31'b0, busy}, 32'd0);
    check("rst_no_ack", {28'b0, hand_ack}, 32'd0);
    repeat (20) step();
    check("rst_no_result", res_cyc.size(), 32'd0);
    check("rst_no_round_done", done_cnt - done_before, 32'd0);

    clear_logs();
    set_hand(0, mk(cd(4, S), cd(4, H), cd(4, D), cd(9, C), cd(2, S)));
    set_hand(1, mk(cd(6, S), cd(6, H), cd(11, D), cd(11, C), cd(3, S)));
    set_hand(2, mk(cd(8, S), cd(8, H), cd(8, D), cd(12, C), cd(12, S)));
    hand_valid = 4'b0111;
    exp_q.push_back('{0, 3});
    exp_q.push_back('{1, 2});
    exp_q.push_back('{2, 6});
    start_round(4'b0111);
    wait_done(2, 6);
    check_acks(3);

    // 6: empty mask finishes at once; then an unmasked requester is never served
    clear_logs();
    hand_valid = 4'b0000;
    start_round(4'b0000);
    check("empty_done_next_cycle", {31'b0, round_done}, 32'd1);
    wait_done(0, 0);

    clear_logs();
    hand_valid = 4'b0010;
    start_round(4'b0100);
    repeat (40) step();
    check("unmasked_never_acked", ack_cyc.size(), 32'd0);
    check("stalled_round_busy", {31'b0, busy}, 32'd1);
    set_hand(2, mk(cd(14, S), cd(14, H), cd(2, D), cd(3, C), cd(4, S)));
    exp_q.push_back('{2, 1});
    hand_valid = 4'b0110;
    wait_done(2, 1);
    check("masked_ack_count", ack_cyc.size(), 32'd1);
    if (ack_vec.size() > 0) check("masked_ack_p2", {28'b0, ack_vec[0]}, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
